rvx_board_conditioner: RTL and testbench

Board-level clock-enable, input debouncing and system-reset sequencing block for RVX FPGA top levels. It sits between the board pins and the `rvx_ocelot` instance and replaces ad-hoc toggle-flop dividers and single-flop "debouncers" with a parametrised clock-enable generator, N-channel counter-based debouncers and a reset stretcher. It drives the SoC's `reset_n`.

---
 rtl/rvx_board_conditioner.sv | 148 ++++++++++++++
 tb/tb_rvx_board_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rvx_board_conditioner.sv
// Board-side conditioning for RVX tops: clock-enable divider, N-channel debouncers and SoC reset sequencing.
// Define RVX_DEBOUNCE_EDGE_EN to build the registered rising_edge/falling_edge pulses; otherwise they are tied low.
module rvx_board_conditioner #(
   parameter int CLOCK_DIVIDER     = 2,
   parameter int NUM_INPUTS        = 1,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int RESET_INPUT_INDEX = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_INPUTS-1:0] raw_inputs,
   output logic                  clock_enable,
   output logic [NUM_INPUTS-1:0] debounced,
   output logic [NUM_INPUTS-1:0] rising_edge,
   output logic [NUM_INPUTS-1:0] falling_edge,
   output logic                  reset_n_out
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DIV_W  = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
   localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

   localparam logic [1:0] ST_ASSERT = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   logic [NUM_INPUTS-1:0] meta;
   logic [NUM_INPUTS-1:0] sync;
   logic [CNT_W-1:0]      deb_count [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] flip;
   logic [DIV_W-1:0]      div_count;
   logic                  div_wrap;
   logic [1:0]            state;
   logic [HOLD_W-1:0]     hold_count;
   logic                  button;
   logic                  button_prev;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= raw_inputs;
         sync <= meta;
      end
   end

   // A channel flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
   always_comb begin
      flip = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         flip[i] = (sync[i] != debounced[i]) && (deb_count[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            deb_count[i] <= '0;
         end
         debounced <= '0;
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if ((sync[i] == debounced[i]) || flip[i]) begin
               deb_count[i] <= '0;
            end else begin
               deb_count[i] <= deb_count[i] + CNT_W'(1);
            end
         end
         debounced <= debounced ^ flip;
      end
   end

`ifdef RVX_DEBOUNCE_EDGE_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         rising_edge  <= '0;
         falling_edge <= '0;
      end else begin
         rising_edge  <= flip & ~debounced;
         falling_edge <= flip & debounced;
      end
   end
`else
   assign rising_edge  = '0;
   assign falling_edge = '0;
`endif

   assign div_wrap = (div_count == DIV_W'(CLOCK_DIVIDER - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         div_count    <= '0;
         clock_enable <= 1'b0;
      end else begin
         clock_enable <= div_wrap;
         div_count    <= div_wrap ? '0 : div_count + DIV_W'(1);
      end
   end

   assign button = debounced[RESET_INPUT_INDEX];

   // Holding the reset button keeps the hold counter pinned at zero, stretching the reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_ASSERT;
         hold_count  <= '0;
         button_prev <= 1'b0;
         reset_n_out <= 1'b0;
      end else begin
         button_prev <= button;
         case (state)
            ST_ASSERT: begin
               state       <= ST_HOLD;
               hold_count  <= '0;
               reset_n_out <= 1'b0;
            end
            ST_HOLD: begin
               if (button) begin
                  hold_count <= '0;
               end else if (clock_enable) begin
                  if (hold_count == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
                     state       <= ST_RUN;
                     hold_count  <= HOLD_W'(RESET_HOLD_CYCLES);
                     reset_n_out <= 1'b1;
                  end else begin
                     hold_count <= hold_count + HOLD_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (button && !button_prev) begin
                  state       <= ST_HOLD;
                  hold_count  <= '0;
                  reset_n_out <= 1'b0;
               end
            end
            default: begin
               state       <= ST_ASSERT;
               hold_count  <= '0;
               reset_n_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rvx_board_conditioner.sv
// Self-checking bench for rvx_board_conditioner: directed scenarios plus random pin activity,
// compared every cycle against a window-based behavioural model.
module tb_rvx_board_conditioner;

   localparam int DIV  = 4;
   localparam int NIN  = 2;
   localparam int DEB  = 8;
   localparam int HOLD = 3;
   localparam int RIDX = 0;
`ifdef RVX_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [NIN-1:0] raw_inputs = '0;
   logic           clock_enable;
   logic [NIN-1:0] debounced;
   logic [NIN-1:0] rising_edge;
   logic [NIN-1:0] falling_edge;
   logic           reset_n_out;

   int check_count = 0;
   int error_count = 0;

   rvx_board_conditioner #(
      .CLOCK_DIVIDER    (DIV),
      .NUM_INPUTS       (NIN),
      .DEBOUNCE_CYCLES  (DEB),
      .RESET_HOLD_CYCLES(HOLD),
      .RESET_INPUT_INDEX(RIDX)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .raw_inputs  (raw_inputs),
      .clock_enable(clock_enable),
      .debounced   (debounced),
      .rising_edge (rising_edge),
      .falling_edge(falling_edge),
      .reset_n_out (reset_n_out)
   );

   always #5 clock = ~clock;

   // Model state: cycle index since reset release, pin history, and reset-tick bookkeeping.
   bit             model_valid = 1'b0;
   int             k;
   int             tick;
   int             last_flip [NIN];
   bit             all_diff;
   logic [NIN-1:0] samp_hist [64];
   logic [NIN-1:0] sync_hist [64];
   logic [NIN-1:0] m_deb, m_rise, m_fall;
   logic           m_ce, m_rn;

   // Outputs are derived from rules: divider phase, "DEB consecutive disagreeing synchronized
   // samples since the last flip", and "HOLD ticks seen since the button was last down".
   always @(posedge clock) begin
      if (reset) begin
         model_valid = 1'b1;
         k = 0;
         tick = 0;
         m_deb = '0;
         m_rise = '0;
         m_fall = '0;
         m_ce = 1'b0;
         m_rn = 1'b0;
         for (int i = 0; i < NIN; i++) last_flip[i] = 0;
      end else begin
         k++;
         if (m_deb[RIDX]) tick = 0;
         else if (m_ce && tick < HOLD) tick++;
         m_rn = (tick >= HOLD);
         m_ce = ((k % DIV) == 0);
         samp_hist[k % 64] = raw_inputs;
         sync_hist[k % 64] = (k >= 3) ? samp_hist[(k - 2) % 64] : '0;
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < NIN; i++) begin
            all_diff = 1'b1;
            if (k - DEB + 1 <= last_flip[i]) begin
               all_diff = 1'b0;
            end else begin
               for (int m = k - DEB + 1; m <= k; m++) begin
                  if (sync_hist[m % 64][i] == m_deb[i]) all_diff = 1'b0;
               end
            end
            if (all_diff) begin
               m_deb[i] = ~m_deb[i];
               last_flip[i] = k;
               if (m_deb[i]) m_rise[i] = 1'b1;
               else m_fall[i] = 1'b1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clock) begin
      if (model_valid) begin
         checkOutput("model_clock_enable", 32'(clock_enable), 32'(m_ce));
         checkOutput("model_debounced", 32'(debounced), 32'(m_deb));
         checkOutput("model_rising_edge", 32'(rising_edge), 32'(EDGE_EN ? m_rise : 2'b00));
         checkOutput("model_falling_edge", 32'(falling_edge), 32'(EDGE_EN ? m_fall : 2'b00));
         checkOutput("model_reset_n_out", 32'(reset_n_out), 32'(m_rn));
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic applyStimulus(input logic [NIN-1:0] pins, input logic rst, input int cycles);
      raw_inputs = pins;
      reset = rst;
      wait_edges(cycles);
   endtask

   initial begin
      $display("[TB] starting");
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_rn", 32'(reset_n_out), 32'd0);
      checkOutput("reset_deb", 32'(debounced), 32'd0);
      checkOutput("reset_ce", 32'(clock_enable), 32'd0);

      // Reset then idle: enables at cycles 4, 8, 12; reset_n_out rises at cycle 13.
      reset = 1'b0;
      wait_edges(3);
      checkOutput("idle_ce_c3", 32'(clock_enable), 32'd0);
      wait_edges(1);
      checkOutput("idle_ce_c4", 32'(clock_enable), 32'd1);
      wait_edges(4);
      checkOutput("idle_ce_c8", 32'(clock_enable), 32'd1);
      wait_edges(4);
      checkOutput("idle_rn_c12", 32'(reset_n_out), 32'd0);
      wait_edges(1);
      checkOutput("idle_rn_c13", 32'(reset_n_out), 32'd1);
      wait_edges(6);

      // Clean press on channel 1.
      applyStimulus(2'b10, 1'b0, 9);
      checkOutput("press_deb_c9", 32'(debounced), 32'd0);
      wait_edges(1);
      checkOutput("press_deb_c10", 32'(debounced), 32'd2);
      checkOutput("press_rise_c10", 32'(rising_edge), EDGE_EN ? 32'd2 : 32'd0);
      wait_edges(1);
      checkOutput("press_rise_c11", 32'(rising_edge), 32'd0);
      wait_edges(9);
      applyStimulus(2'b00, 1'b0, 9);
      checkOutput("release_deb_c9", 32'(debounced), 32'd2);
      wait_edges(1);
      checkOutput("release_deb_c10", 32'(debounced), 32'd0);
      checkOutput("release_fall_c10", 32'(falling_edge), EDGE_EN ? 32'd2 : 32'd0);
      wait_edges(5);

      // Bounce every 5 cycles, then a single 7-cycle excursion.
      for (int t = 0; t < 8; t++) applyStimulus((t % 2 == 0) ? 2'b10 : 2'b00, 1'b0, 5);
      checkOutput("bounce_deb", 32'(debounced), 32'd0);
      applyStimulus(2'b10, 1'b0, 7);
      applyStimulus(2'b00, 1'b0, 12);
      checkOutput("bounce7_deb", 32'(debounced), 32'd0);

      // Reset button pressed while running.
      applyStimulus(2'b01, 1'b0, 10);
      checkOutput("btn_deb_c10", 32'(debounced), 32'd1);
      checkOutput("btn_rn_c10", 32'(reset_n_out), 32'd1);
      wait_edges(1);
      checkOutput("btn_rn_c11", 32'(reset_n_out), 32'd0);
      wait_edges(19);
      checkOutput("btn_rn_held", 32'(reset_n_out), 32'd0);
      applyStimulus(2'b00, 1'b0, 10);
      checkOutput("btn_deb_fall", 32'(debounced), 32'd0);
      wait_edges(1);
      checkOutput("btn_rn_after_fall", 32'(reset_n_out), 32'd0);
      wait_edges(19);
      checkOutput("btn_rn_recovered", 32'(reset_n_out), 32'd1);

      // Block reset mid-hold and mid-debounce; counts restart from the release.
      applyStimulus(2'b01, 1'b0, 12);
      applyStimulus(2'b11, 1'b0, 6);
      applyStimulus(2'b11, 1'b1, 1);
      checkOutput("midrst_deb", 32'(debounced), 32'd0);
      checkOutput("midrst_rn", 32'(reset_n_out), 32'd0);
      checkOutput("midrst_ce", 32'(clock_enable), 32'd0);
      applyStimulus(2'b11, 1'b0, 9);
      checkOutput("midrst_deb_c9", 32'(debounced), 32'd0);
      wait_edges(1);
      checkOutput("midrst_deb_c10", 32'(debounced), 32'd3);
      applyStimulus(2'b00, 1'b0, 30);

      // Random pin activity with occasional block resets.
      for (int t = 0; t < 1200; t++) begin
         if ($urandom_range(0, 40) == 0) applyStimulus(2'($urandom), 1'b1, 1);
         else applyStimulus(2'($urandom), 1'b0, $urandom_range(1, 14));
      end
      applyStimulus(2'b00, 1'b0, 40);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
